uart_ctrl: RTL
==============

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, meaning clock cycles per UART bit (9600 baud at 50 MHz); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rd  input  1  peripheral read strobe, one cycle per access.
REQ-005 SHALL have port wr  input  1  peripheral write strobe, one cycle per access.
REQ-006 SHALL have port addr  input  4  byte offset: 0x0 TXD, 0x4 RXD, 0x8 CON; other offsets read 0 and ignore writes.
REQ-007 SHALL have port wdata  input  32  write data; only bits used by the addressed register matter.
REQ-008 SHALL have port rdata  output  32  registered read data.
REQ-009 SHALL have port uart_rx  input  1  asynchronous serial input, idle high.
REQ-010 SHALL have port uart_tx  output  1  serial output, idle high.
REQ-011 SHALL have port irq  output  1  level interrupt to CPU.

Function
REQ-012 SHALL frame 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each exactly CLK_DIV cycles.
REQ-013 SHALL implement TX FSM IDLE->START->DATA(bit count 0..7)->STOP->IDLE; wr to TXD in IDLE latches wdata[7:0], sets tx_busy, enters START next cycle.
REQ-014 SHALL ignore TXD writes while tx_busy=1 (no data change, no state change).
REQ-015 SHALL clear tx_busy and set sticky tx_done in the cycle STOP completes.
REQ-016 SHALL synchronise uart_rx through two flops before any use.
REQ-017 SHALL implement RX FSM IDLE->START->DATA->STOP->IDLE; IDLE->START on synchronised 1->0 edge.
REQ-018 SHALL resample at CLK_DIV/2 in START; if high, treat as glitch and return to IDLE with no status change.
REQ-019 SHALL sample each data bit and stop bit at mid-bit, CLK_DIV cycles apart.
REQ-020 SHALL, on stop=1, load rx_data and set rx_valid; if rx_valid was already 1, overwrite rx_data and set sticky rx_ovr.
REQ-021 SHALL, on stop=0, discard the byte, set sticky frame_err, leave rx_data/rx_valid unchanged.
REQ-022 SHALL return rdata in the cycle after rd: RXD={24'b0,rx_data}; TXD={24'b0,last tx byte}; CON={26'b0,rx_ovr,frame_err,tx_done,rx_valid,tx_busy,irq_en}.
REQ-023 SHALL clear rx_valid on an RXD read, and tx_done, rx_ovr, frame_err on a CON read, all in the rd cycle.
REQ-024 SHALL give set priority over read-clear when both occur in one cycle (flag remains 1).
REQ-025 SHALL write irq_en from wdata[0] on wr to CON; other CON bits read-only.
REQ-026 SHALL drive irq = irq_en & (rx_valid | tx_done), registered, one cycle after flag change.
REQ-027 SHALL run TX and RX fully independently and concurrently.
REQ-028 SHALL ignore rd and wr asserted together (no side effects, rdata unchanged).

Reset
REQ-029 SHALL on reset low immediately force: uart_tx=1, irq=0, rdata=0, both FSMs IDLE, all counters 0, rx_data=0, tx byte=0, all status flags and irq_en 0.
REQ-030 SHALL abort any frame in progress at reset; no partial byte is ever reported after release.
REQ-031 SHALL preset both synchroniser flops to 1 so release does not create a false start edge.

Structure
REQ-032 SHALL place register offsets, CON bit indices and TX/RX state encodings in shared package uart_pkg.
REQ-033 SHALL instantiate one sub-module uart_rx_fsm (synchroniser, RX FSM, bit counter); TX FSM, registers and irq stay in uart_ctrl.

Verification (CLK_DIV=16)
REQ-034 SHALL check write TXD=0x5A -> uart_tx low 16 cycles, bits 0,1,0,1,1,0,1,0, high 16; tx_busy 1 throughout, then tx_done=1.
REQ-035 SHALL check serial 0xA5 on uart_rx -> rx_valid=1, RXD read gives 0x000000A5, rx_valid 0 next CON read.
REQ-036 SHALL check two frames 0x11, 0x22 unread -> RXD=0x22, CON rx_ovr=1; CON read clears rx_ovr.
REQ-037 SHALL check frame 0x33 with stop bit 0 -> frame_err=1, rx_valid stays 0; 4-cycle low glitch -> no status change.
REQ-038 SHALL check irq_en=1 then TX done -> irq=1; CON read -> irq=0; reset mid-TX -> uart_tx=1 same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, CON bit positions and FSM encodings for the UART controller.
package uart_pkg;

    localparam logic [3:0] ADDR_TXD = 4'h0;
    localparam logic [3:0] ADDR_RXD = 4'h4;
    localparam logic [3:0] ADDR_CON = 4'h8;

    localparam int CON_IRQ_EN    = 0;
    localparam int CON_TX_BUSY   = 1;
    localparam int CON_RX_VALID  = 2;
    localparam int CON_TX_DONE   = 3;
    localparam int CON_FRAME_ERR = 4;
    localparam int CON_RX_OVR    = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [31:0] con_word(input logic irq_en, input logic tx_busy,
                                             input logic rx_valid, input logic tx_done,
                                             input logic frame_err, input logic rx_ovr);
        logic [31:0] w;
        w = '0;
        w[CON_IRQ_EN]    = irq_en;
        w[CON_TX_BUSY]   = tx_busy;
        w[CON_RX_VALID]  = rx_valid;
        w[CON_TX_DONE]   = tx_done;
        w[CON_FRAME_ERR] = frame_err;
        w[CON_RX_OVR]    = rx_ovr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// 8N1 receiver: two-flop synchroniser, start-bit qualification and mid-bit sampling.
// done_o / frame_err_o are single-cycle pulses; data_o is valid while done_o is high.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 5208
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx_i,
    output logic [7:0] data_o,
    output logic      done_o,
    output logic      frame_err_o,
    output rx_state_e state_o
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

    logic      sync1_q, sync2_q, prev_q;
    rx_state_e state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        done_q, ferr_q;

    // Synchroniser presets high so releasing reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            state_q <= RX_IDLE;
                        end else begin
                            state_q <= RX_DATA;
                            bit_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= RX_IDLE;
                        if (sync2_q) begin
                            done_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign data_o      = shift_q;
    assign done_o      = done_q;
    assign frame_err_o = ferr_q;
    assign state_o     = state_q;

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART: TXD/RXD/CON registers, 8N1 transmitter and level interrupt.
// Bus handshake: rd/wr are one-cycle strobes; rdata is valid the cycle after rd; rd+wr together is a no-op.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic rd_en, wr_en;
    assign rd_en = rd & ~wr;
    assign wr_en = wr & ~rd;

    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_byte_q;
    logic        tx_q, tx_busy_q;
    logic        tx_start, tx_finish;

    logic [7:0]  rx_byte;
    logic        rx_done, rx_ferr;
    rx_state_e   rx_state;

    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic        frame_err_q, frame_err_d;
    logic        tx_done_q, tx_done_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_rxd, rd_con;

    assign tx_start  = wr_en && (addr == ADDR_TXD) && (tx_state_q == TX_IDLE);
    assign tx_finish = (tx_state_q == TX_STOP) && (tx_cnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_byte_q  <= wdata[7:0];
                        tx_busy_q  <= 1'b1;
                        tx_state_q <= TX_START;
                        tx_cnt_q   <= '0;
                        tx_q       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == DIV_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                        tx_q       <= tx_byte_q[0];
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == DIV_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_q     <= tx_byte_q[tx_bit_q + 3'd1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_finish) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_IDLE;
                        tx_busy_q  <= 1'b0;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    uart_rx_fsm #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx_i       (uart_rx),
        .data_o     (rx_byte),
        .done_o     (rx_done),
        .frame_err_o(rx_ferr),
        .state_o    (rx_state)
    );

    assign rd_rxd = rd_en && (addr == ADDR_RXD);
    assign rd_con = rd_en && (addr == ADDR_CON);

    // Read-clears are applied first so a coincident set wins.
    always_comb begin
        rx_data_d   = rx_done ? rx_byte : rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_ovr_d    = rx_ovr_q;
        frame_err_d = frame_err_q;
        tx_done_d   = tx_done_q;
        irq_en_d    = irq_en_q;
        rdata_d     = rdata_q;
        if (rd_rxd) rx_valid_d = 1'b0;
        if (rd_con) begin
            rx_ovr_d    = 1'b0;
            frame_err_d = 1'b0;
            tx_done_d   = 1'b0;
        end
        if (rx_done) begin
            rx_valid_d = 1'b1;
            if (rx_valid_q) rx_ovr_d = 1'b1;
        end
        if (rx_ferr)   frame_err_d = 1'b1;
        if (tx_finish) tx_done_d   = 1'b1;
        if (wr_en && (addr == ADDR_CON)) irq_en_d = wdata[0];
        if (rd_en) begin
            case (addr)
                ADDR_TXD: rdata_d = {24'b0, tx_byte_q};
                ADDR_RXD: rdata_d = {24'b0, rx_data_q};
                ADDR_CON: rdata_d = con_word(irq_en_q, tx_busy_q, rx_valid_q,
                                             tx_done_q, frame_err_q, rx_ovr_q);
                default:  rdata_d = '0;
            endcase
        end
        irq_d = irq_en_q & (rx_valid_q | tx_done_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_done_q   <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            tx_done_q   <= tx_done_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
        end
    end

    assign uart_tx = tx_q;
    assign irq     = irq_q;
    assign rdata   = rdata_q;

endmodule
